// File: rtl/gray2bin_sync.sv
// gray2bin_sync: receive-side decoder for a Gray-coded counter from a foreign
// clock domain. It synchronises the bus and decodes it to binary in a two-stage
// pipeline. Each advance is reported as a valid pulse with its modular step.
// Any sample-to-sample change of more than one Gray bit is flagged and counted.
module gray2bin_sync #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] gray_in,
    input  logic                  enable,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] bin_out,
    output logic                  bin_valid,
    output logic [DATA_WIDTH-1:0] delta,
    output logic                  step_err,
    output logic [15:0]           err_count,
    output logic                  ready
);

    // Warm-up length in edges: sync chain, stage 1, and one absorbing stage-2 load.
    localparam int WARM_EDGES = SYNC_STAGES + 2;
    localparam int CNT_W      = $clog2(WARM_EDGES + 1);

    // Gray to binary: the MSB is copied, and each lower bit is XORed with the decoded bit above it.
    function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
        logic [DATA_WIDTH-1:0] b;
        b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
        for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] g_s;
    logic [DATA_WIDTH-1:0] g_prev_q;
    logic [DATA_WIDTH-1:0] g_diff;
    logic                  multi_bit;
    logic [DATA_WIDTH-1:0] b1_q;
    logic                  err1_q;

    logic [DATA_WIDTH-1:0] bin_q,      bin_d;
    logic [DATA_WIDTH-1:0] delta_q,    delta_d;
    logic                  valid_q,    valid_d;
    logic                  step_err_q, step_err_d;
    logic [15:0]           err_cnt_q,  err_cnt_d;
    logic [CNT_W-1:0]      warm_cnt_q, warm_cnt_d;
    logic                  ready_q,    ready_d;

    assign g_s = sync_q[SYNC_STAGES-1];

    // x & (x - 1) clears the lowest set bit, so a non-zero result means two or more bits differ.
    assign g_diff    = g_s ^ g_prev_q;
    assign multi_bit = |(g_diff & (g_diff - DATA_WIDTH'(1)));

    // Plain flop chain for the asynchronous Gray bus, with no logic between stages.
    // NOTE: the synchroniser is a small flop array rather than a RAM, so every stage is reset to a known zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the old value of the stage before it.
            sync_q[0] <= gray_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Stage 1 runs every cycle: decode, keep the previous sample, and detect multi-bit steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_prev_q <= '0;
            b1_q     <= '0;
            err1_q   <= 1'b0;
        end else begin
            g_prev_q <= g_s;
            b1_q     <= gray2bin(g_s);
            err1_q   <= multi_bit;
        end
    end

    // Warm-up sequencing: ready rises on the WARM_EDGES-th edge after reset and then stays high.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        warm_cnt_d = warm_cnt_q;
        ready_d    = ready_q;
        if (!ready_q) begin
            warm_cnt_d = warm_cnt_q + 1'b1;
            if (warm_cnt_q == CNT_W'(WARM_EDGES - 1)) ready_d = 1'b1;
        end
    end

    // Stage 2 next state. Warm-up silently absorbs b1; a freeze holds value and delta.
    always_comb begin
        bin_d      = bin_q;
        delta_d    = delta_q;
        valid_d    = 1'b0;
        step_err_d = 1'b0;
        if (!ready_q) begin
            bin_d   = b1_q;
            delta_d = '0;
        end else if (enable) begin
            valid_d    = (b1_q != bin_q);
            step_err_d = err1_q;
            if (b1_q != bin_q) begin
                delta_d = b1_q - bin_q;
                bin_d   = b1_q;
            end
        end
    end

    // Saturating error counter. A synchronous clear takes priority over a coincident increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clear_err) begin
            err_cnt_d = '0;
        end else if (step_err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Stage 2, error counter and warm-up registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q      <= '0;
            delta_q    <= '0;
            valid_q    <= 1'b0;
            step_err_q <= 1'b0;
            err_cnt_q  <= '0;
            warm_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            bin_q      <= bin_d;
            delta_q    <= delta_d;
            valid_q    <= valid_d;
            step_err_q <= step_err_d;
            err_cnt_q  <= err_cnt_d;
            warm_cnt_q <= warm_cnt_d;
            ready_q    <= ready_d;
        end
    end

    assign bin_out   = bin_q;
    assign delta     = delta_q;
    assign bin_valid = valid_q;
    assign step_err  = step_err_q;
    assign err_count = err_cnt_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_gray2bin_sync.sv
// Directed testbench for gray2bin_sync with W=4 and S=2. Outputs are sampled
// 1 time unit after each rising edge.
module tb_gray2bin_sync;

    logic        clk;
    logic        rst;
    logic [3:0]  gray_in;
    logic        enable;
    logic        clear_err;
    logic [3:0]  bin_out;
    logic        bin_valid;
    logic [3:0]  delta;
    logic        step_err;
    logic [15:0] err_count;
    logic        ready;

    int n_cmp = 0;
    int n_err = 0;
    int pulses;
    int bad;

    gray2bin_sync #(.DATA_WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .enable    (enable),
        .clear_err (clear_err),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .delta     (delta),
        .step_err  (step_err),
        .err_count (err_count),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] to_gray(input int k);
        return 4'(k ^ (k >> 1));
    endfunction

    logic [3:0] freeze_seq [4];

    initial begin
        rst       = 1'b1;
        gray_in   = 4'b0000;
        enable    = 1'b1;
        clear_err = 1'b0;
        freeze_seq[0] = 4'b0101;  // 6
        freeze_seq[1] = 4'b0100;  // 7
        freeze_seq[2] = 4'b1100;  // 8
        freeze_seq[3] = 4'b1101;  // 9

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_bin_out",   32'(bin_out),   32'd0);
        check("rst_ready",     32'(ready),     32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_bin_valid", 32'(bin_valid), 32'd0);
        rst = 1'b0;

        // Warm-up: ready rises on edge 4
        repeat (3) tick();
        check("warm_ready_e3", 32'(ready), 32'd0);
        tick();
        check("warm_ready_e4", 32'(ready), 32'd1);
        check("warm_bin_out",  32'(bin_out), 32'd0);

        // Gray count 1..15, one step every 4 clocks, with a latency of 4 edges
        pulses = 0;
        for (int k = 1; k < 16; k++) begin
            gray_in = to_gray(k);
            for (int t = 1; t <= 4; t++) begin
                tick();
                if (bin_valid) pulses++;
                if (t == 3) check($sformatf("seq%0d_early", k), 32'(bin_out), 32'(k - 1));
                if (t == 4) begin
                    check($sformatf("seq%0d_bin", k),   32'(bin_out),   32'(k));
                    check($sformatf("seq%0d_valid", k), 32'(bin_valid), 32'd1);
                    check($sformatf("seq%0d_delta", k), 32'(delta),     32'd1);
                    check($sformatf("seq%0d_serr", k),  32'(step_err),  32'd0);
                end
            end
        end

        // Wrap-around 15 -> 0: gray 1000 -> 0000
        gray_in = 4'b0000;
        for (int t = 1; t <= 4; t++) begin
            tick();
            if (bin_valid) pulses++;
        end
        check("wrap_bin",    32'(bin_out),   32'd0);
        check("wrap_valid",  32'(bin_valid), 32'd1);
        check("wrap_delta",  32'(delta),     32'd1);
        check("wrap_serr",   32'(step_err),  32'd0);
        check("seq_pulses",  32'(pulses),    32'd16);
        check("seq_err_cnt", 32'(err_count), 32'd0);

        // Two-bit jump 0000 -> 0011 (bin 2)
        gray_in = 4'b0011;
        repeat (4) tick();
        check("jump_bin",   32'(bin_out),   32'd2);
        check("jump_valid", 32'(bin_valid), 32'd1);
        check("jump_delta", 32'(delta),     32'd2);
        check("jump_serr",  32'(step_err),  32'd1);
        tick();
        check("jump_serr_pulse", 32'(step_err),  32'd0);
        check("jump_err_cnt",    32'(err_count), 32'd1);

        // Move to 5 (0011 -> 0111, a single-bit change)
        gray_in = 4'b0111;
        repeat (4) tick();
        check("to5_bin",   32'(bin_out),  32'd5);
        check("to5_delta", 32'(delta),    32'd3);
        check("to5_serr",  32'(step_err), 32'd0);

        // Count 6..9 while disabled, then re-enable
        enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            gray_in = freeze_seq[i];
            repeat (2) begin
                tick();
                if (bin_valid || step_err) bad++;
            end
        end
        repeat (4) begin
            tick();
            if (bin_valid || step_err) bad++;
        end
        check("freeze_pulses", 32'(bad),     32'd0);
        check("freeze_bin",    32'(bin_out), 32'd5);
        enable = 1'b1;
        tick();
        check("reen_valid", 32'(bin_valid), 32'd1);
        check("reen_bin",   32'(bin_out),   32'd9);
        check("reen_delta", 32'(delta),     32'd4);
        check("reen_serr",  32'(step_err),  32'd0);
        tick();
        check("reen_single", 32'(bin_valid), 32'd0);

        // Saturate err_count with a two-bit toggle on every cycle
        for (int i = 0; i < 65600; i++) begin
            gray_in = (i % 2 == 1) ? 4'b0011 : 4'b0000;
            tick();
        end
        check("sat_err_cnt", 32'(err_count), 32'h0000FFFF);
        check("sat_serr",    32'(step_err),  32'd1);
        gray_in = ~gray_in & 4'b0011;
        tick();
        check("sat_hold",     32'(err_count), 32'h0000FFFF);
        check("sat_serr_pre", 32'(step_err),  32'd1);
        clear_err = 1'b1;
        tick();
        check("clear_priority", 32'(err_count), 32'd0);
        clear_err = 1'b0;

        // Reset mid-stream with gray 0110 (bin 4) held
        gray_in = 4'b0110;
        repeat (6) tick();
        check("pre_rst_bin", 32'(bin_out), 32'd4);
        rst = 1'b1;
        #1;
        check("mrst_bin",   32'(bin_out),   32'd0);
        check("mrst_cnt",   32'(err_count), 32'd0);
        check("mrst_ready", 32'(ready),     32'd0);
        check("mrst_delta", 32'(delta),     32'd0);
        #1;
        rst = 1'b0;
        bad = 0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (bin_valid || step_err) bad++;
            if (e == 3) check("mrst_ready_e3", 32'(ready), 32'd0);
            if (e == 4) begin
                check("mrst_ready_e4", 32'(ready),   32'd1);
                check("mrst_bin_e4",   32'(bin_out), 32'd4);
            end
        end
        check("mrst_pulses",  32'(bad),       32'd0);
        check("mrst_bin_end", 32'(bin_out),   32'd4);
        check("mrst_cnt_end", 32'(err_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
